binary_2scomplement_to_thermometer_serializer: RTL and testbench
================================================================

# binary_2scomplement_to_thermometer_serializer

Serial transmitter for the partial-product adder datapath: takes a parallel {sign, magnitude} word and emits a serial frame of SERIAL_OUTPUT_LENGTH bits. Each frame is one sign bit followed by SERIAL_OUTPUT_LENGTH-1 thermometer bits, ones first. It is the sending end of the serial thermometer link. Its start_out/serial_out pair drives the start/serial_in pair of the thermometer-to-binary receiver directly, so a loopback returns the original word.

## Interface
- SERIAL_OUTPUT_LENGTH, 33: total frame length in bits (sign + thermometer); must be ≥ 3.
- MAG_W (localparam), $clog2(SERIAL_OUTPUT_LENGTH-1): magnitude width (5 for default).

- clk  input  1  single clock; all flops on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to send; honoured only while ready=1.
- data_in  input  MAG_W+1  {sign, magnitude}; sign = MSB; captured on the accepting edge.
- ready  output  1  high only in IDLE; reset value 1.
- start_out  output  1  one-cycle pulse one cycle before the sign bit; reset value 0.
- serial_out  output  1  frame bit stream; 0 whenever serial_valid=0; reset value 0.
- serial_valid  output  1  high for exactly SERIAL_OUTPUT_LENGTH consecutive cycles per frame; reset value 0.
- done  output  1  one-cycle pulse after the last frame bit; reset value 0.

## Operation
- All outputs are driven from flops: Moore decode of the registered state, sign register, magnitude register and bit counter.
- States: IDLE → ARM → SIGN → SENDING → DONE → IDLE.
  - IDLE: ready=1. When start=1 at an edge: capture sign_reg=data_in[MAG_W] and mag_reg=data_in[MAG_W-1:0], clear bit_counter to 1, go to ARM.
  - ARM: start_out=1. Unconditionally go to SIGN.
  - SIGN: serial_valid=1, serial_out=sign_reg. Go to SENDING.
  - SENDING: serial_valid=1, serial_out = (bit_counter ≤ mag_eff). bit_counter increments each cycle. When bit_counter == SERIAL_OUTPUT_LENGTH-1, go to DONE.
  - DONE: done=1, serial_valid=0. Go to IDLE.
- mag_eff = min(mag_reg, SERIAL_OUTPUT_LENGTH-1). Saturation applies when 2^MAG_W-1 exceeds SERIAL_OUTPUT_LENGTH-1; in that case all thermometer bits are 1.
- bit_counter width is $clog2(SERIAL_OUTPUT_LENGTH)+1; it never wraps within a frame.
- Thermometer bits are contiguous: mag_eff ones, then zeros. Magnitude 0 gives all zeros.
- start is ignored in ARM, SIGN, SENDING and DONE; no queuing. data_in changes after capture have no effect on the frame in flight.
- Illegal or unreachable state encodings go to IDLE with all outputs at reset values.
- rst asserted at any time: immediately IDLE, ready=1, all other outputs 0, registers cleared. The partial frame is abandoned and no done pulse is issued.

## Timing
- With capture at edge E0 (cycle 0 = start sampled in IDLE):
  - Cycle 1: start_out=1, ready=0.
  - Cycle 2: sign bit, serial_valid=1.
  - Cycles 3..SERIAL_OUTPUT_LENGTH+1: thermometer bits 1..L-1.
  - Cycle L+2: done=1.
  - Cycle L+3: ready=1.
- For the default: sign in cycle 2, thermometer bits in cycles 3–34, done in cycle 35, ready in cycle 36.
- Frame period with start held high: SERIAL_OUTPUT_LENGTH+3 cycles (36 for default). The next frame is accepted in the first IDLE cycle.
- Receiver alignment: start_out in cycle N places the sign bit in cycle N+1, matching the receiver's START-state sampling. The receiver's result is valid 2 cycles after this block's last serial bit.

## Test plan
- data_in=6'b000101 (+5), default length → cycle 2 serial_out=0; cycles 3–7 =1; cycles 8–34 =0; serial_valid high cycles 2–34 only; done in cycle 35.
- data_in=6'b111111 (sign 1, magnitude 31) in loopback to the receiver → stream 1 then 31 ones then 1 zero. Receiver outputs thermometer_sum_out=31 and thermometer_result_2scomp_out=6'b111111.
- data_in=6'b000000 → sign 0, 32 zeros, done pulse. Then data_in=6'b100000 → sign 1, 32 zeros; loopback result 6'b100000.
- SERIAL_OUTPUT_LENGTH=25, data_in=6'b011111 (magnitude 31 > 24) → 24 thermometer ones (saturated), frame length 25, done in cycle 27.
- start pulsed in cycles 5 and 20 mid-frame with different data_in → ignored; frame bits unchanged; exactly one done. start held high continuously → second start_out at cycle 37.
- rst asserted in cycle 10 mid-frame → same-cycle serial_valid=0, serial_out=0, ready=1, no done. A new start after reset release produces a complete, correct frame.

Source files
------------

// File: rtl/binary_2scomplement_to_thermometer_serializer.sv
// binary_2scomplement_to_thermometer_serializer
//
// Serial transmitter for the thermometer link. A parallel {sign, magnitude} word is captured
// while idle and sent as one sign bit followed by SERIAL_OUTPUT_LENGTH-1 thermometer bits
// (ones first). start_out pulses one cycle before the sign bit so a directly connected
// thermometer-to-binary receiver can align on it.
//
// Ports
//   clk          : clock, all flops on the rising edge
//   rst          : asynchronous active-high reset
//   start        : send request, honoured only while ready=1
//   data_in      : {sign, magnitude}, captured on the accepting edge
//   ready        : high only in idle
//   start_out    : one-cycle pulse one cycle before the sign bit
//   serial_out   : frame bit stream, 0 whenever serial_valid=0
//   serial_valid : high for the SERIAL_OUTPUT_LENGTH frame cycles
//   done         : one-cycle pulse after the last frame bit
//
// SERIAL_OUTPUT_LENGTH must be at least 3.
module binary_2scomplement_to_thermometer_serializer #(
  parameter int unsigned SERIAL_OUTPUT_LENGTH = 33,
  localparam int unsigned MAG_W = $clog2(SERIAL_OUTPUT_LENGTH - 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [MAG_W:0] data_in,
  output logic           ready,
  output logic           start_out,
  output logic           serial_out,
  output logic           serial_valid,
  output logic           done
);

  // One spare bit so the counter can hold SERIAL_OUTPUT_LENGTH-1 without wrapping.
  localparam int unsigned CNT_W = $clog2(SERIAL_OUTPUT_LENGTH) + 1;
  localparam logic [CNT_W-1:0] LastBit = CNT_W'(SERIAL_OUTPUT_LENGTH - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StArm     = 3'd1,
    StSign    = 3'd2,
    StSending = 3'd3,
    StDone    = 3'd4
  } state_e;

  state_e             r_state;
  logic               r_sign;
  logic [MAG_W-1:0]   r_mag;
  logic [CNT_W-1:0]   r_cnt;

  logic [CNT_W-1:0]   w_mag_ext;
  logic [CNT_W-1:0]   w_mag_eff;

  // Magnitudes beyond the thermometer length saturate to an all-ones thermometer.
  assign w_mag_ext = CNT_W'(r_mag);
  assign w_mag_eff = (w_mag_ext > LastBit) ? LastBit : w_mag_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_sign  <= 1'b0;
      r_mag   <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_sign  <= data_in[MAG_W];
            r_mag   <= data_in[MAG_W-1:0];
            r_cnt   <= CNT_W'(1);
            r_state <= StArm;
          end
        end
        StArm:  r_state <= StSign;
        StSign: r_state <= StSending;
        StSending: begin
          if (r_cnt == LastBit) begin
            r_state <= StDone;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  // Moore decode of registered state; unknown encodings show reset-valued outputs.
  always_comb begin
    ready        = 1'b0;
    start_out    = 1'b0;
    serial_out   = 1'b0;
    serial_valid = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      StIdle: ready = 1'b1;
      StArm:  start_out = 1'b1;
      StSign: begin
        serial_valid = 1'b1;
        serial_out   = r_sign;
      end
      StSending: begin
        serial_valid = 1'b1;
        serial_out   = (r_cnt <= w_mag_eff);
      end
      StDone:  done = 1'b1;
      default: ready = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_binary_2scomplement_to_thermometer_serializer.sv
module tb_binary_2scomplement_to_thermometer_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 0: default length 33; instance 1: length 25 (saturation case).
  logic       s0, s1;
  logic [5:0] d0, d1;
  logic       rdy0, so0, sr0, sv0, dn0;
  logic       rdy1, so1, sr1, sv1, dn1;

  binary_2scomplement_to_thermometer_serializer #(.SERIAL_OUTPUT_LENGTH(33)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (s0),
    .data_in      (d0),
    .ready        (rdy0),
    .start_out    (so0),
    .serial_out   (sr0),
    .serial_valid (sv0),
    .done         (dn0)
  );

  binary_2scomplement_to_thermometer_serializer #(.SERIAL_OUTPUT_LENGTH(25)) dut25 (
    .clk          (clk),
    .rst          (rst),
    .start        (s1),
    .data_in      (d1),
    .ready        (rdy1),
    .start_out    (so1),
    .serial_out   (sr1),
    .serial_valid (sv1),
    .done         (dn1)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         sel;
    int         len;
    logic [5:0] d;
    logic       exp_sign;
    int         exp_ones;
  } vec_t;

  // Packed as {ready, start_out, serial_valid, serial_out, done}.
  function automatic logic [4:0] get_out(input int sel);
    if (sel == 0) return {rdy0, so0, sv0, sr0, dn0};
    return {rdy1, so1, sv1, sr1, dn1};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [5:0] d);
    if (sel == 0) begin
      s0 = st;
      d0 = d;
    end else begin
      s1 = st;
      d1 = d;
    end
  endtask

  // Expected outputs in cycle k after capture edge E0, per the frame timing.
  function automatic logic [4:0] model(input int k, input int l, input logic s, input int ones);
    logic e_rdy, e_so, e_sv, e_sr, e_dn;
    e_rdy = (k >= l + 3);
    e_so  = (k == 1);
    e_sv  = (k >= 2) && (k <= l + 1);
    if (k == 2) e_sr = s;
    else e_sr = (k >= 3) && (k <= l + 1) && ((k - 2) <= ones);
    e_dn  = (k == l + 2);
    return {e_rdy, e_so, e_sv, e_sr, e_dn};
  endfunction

  // Entered just after a falling edge with the DUT idle; leaves just after the falling edge of
  // cycle l+3. p1/p2 are cycles in which start is pulsed with data pd (should be ignored).
  task automatic run_frame(input string name, input int sel, input int l, input logic [5:0] d,
                           input logic exp_sign, input int exp_ones, input bit hold,
                           input int p1, input int p2, input logic [5:0] pd);
    logic [4:0] a;
    logic       sign_seen;
    int         ones_seen;
    sign_seen = 1'b0;
    ones_seen = 0;
    drive(sel, 1'b1, d);
    @(posedge clk);
    #1;
    if (!hold) drive(sel, 1'b0, d);
    for (int k = 1; k <= l + 3; k++) begin
      @(negedge clk);
      a = get_out(sel);
      check($sformatf("%s_cyc%0d", name, k), 32'(a), 32'(model(k, l, exp_sign, exp_ones)));
      if (k == 2) sign_seen = a[1];
      if (k >= 3 && a[2] && a[1]) ones_seen++;
      if (k == p1 || k == p2) drive(sel, 1'b1, pd);
      else if (!hold) drive(sel, 1'b0, pd);
    end
    check($sformatf("%s_decoded", name), {sign_seen, 31'(ones_seen)},
          {exp_sign, 31'(exp_ones)});
  endtask

  initial begin
    vec_t       vecs[7];
    logic [4:0] a;
    int         dn_cnt;

    vecs[0] = '{0, 33, 6'b000101, 1'b0, 5};
    vecs[1] = '{0, 33, 6'b111111, 1'b1, 31};
    vecs[2] = '{0, 33, 6'b000000, 1'b0, 0};
    vecs[3] = '{0, 33, 6'b100000, 1'b1, 0};
    vecs[4] = '{0, 33, 6'b011111, 1'b0, 31};
    vecs[5] = '{1, 25, 6'b011111, 1'b0, 24};
    vecs[6] = '{1, 25, 6'b100011, 1'b1, 3};

    rst = 1'b1;
    s0  = 1'b0;
    s1  = 1'b0;
    d0  = '0;
    d1  = '0;
    #12;
    check("reset_dut33", 32'(get_out(0)), 32'h10);
    check("reset_dut25", 32'(get_out(1)), 32'h10);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_frame($sformatf("vec%0d", i), vecs[i].sel, vecs[i].len, vecs[i].d,
                vecs[i].exp_sign, vecs[i].exp_ones, 1'b0, -1, -1, 6'b0);
    end

    // Mid-frame start pulses with different data are ignored.
    run_frame("ignore", 0, 33, 6'b000101, 1'b0, 5, 1'b0, 5, 20, 6'b111010);
    @(negedge clk);
    check("ignore_no_restart", 32'(get_out(0)), 32'h10);

    // start held high: next frame accepted in the first idle cycle.
    run_frame("held", 0, 33, 6'b000011, 1'b0, 3, 1'b1, -1, -1, 6'b000011);
    @(negedge clk);
    check("held_second_start_out", 32'(get_out(0)), 32'h08);
    drive(0, 1'b0, 6'b0);
    repeat (40) @(negedge clk);
    check("held_drained_idle", 32'(get_out(0)), 32'h10);

    // Reset mid-frame abandons the frame without a done pulse.
    drive(0, 1'b1, 6'b000111);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 6'b000111);
    repeat (10) @(negedge clk);
    a = get_out(0);
    check("pre_reset_sending", 32'(a[2]), 32'h1);
    rst = 1'b1;
    #1;
    check("reset_midframe", 32'(get_out(0)), 32'h10);
    @(negedge clk);
    rst = 1'b0;
    dn_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dn0) dn_cnt++;
    end
    check("reset_no_done", 32'(dn_cnt), 32'h0);
    run_frame("after_reset", 0, 33, 6'b101001, 1'b1, 9, 1'b0, -1, -1, 6'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
